stdout_arbiter: RTL and testbench

STDOUT_ARBITER -- requirements
Module: stdout_arbiter

---
 rtl/stdout_arbiter.sv | 91 +++++++++
 tb/tb_stdout_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/stdout_arbiter.sv
// Round-robin arbiter sharing one stdOut word channel among NUM_REQ requesters.
// Define STDOUT_ARB_SOURCE_TAG_EN to add stdOutSourceOutput (index of the granted requester).
module stdout_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                          clockInput,
    input  logic                          resetInput,
    input  logic [NUM_REQ-1:0]            reqReadyInput,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataInput,
    output logic [NUM_REQ-1:0]            reqAckOutput,
    output logic                          stdOutReadyOutput,
    output logic [DATA_WIDTH-1:0]         stdOutDataOutput,
`ifdef STDOUT_ARB_SOURCE_TAG_EN
    output logic [IDX_W-1:0]              stdOutSourceOutput,
`endif
    input  logic                          stdOutAckInput
);

    typedef enum logic [1:0] {IDLE, SEND, ACKREQ} state_t;

    state_t           state;
    logic [IDX_W-1:0] lastGrant;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Search upward from lastGrant+1; NUM_REQ is a power of two so the add wraps naturally.
    always_comb begin
        pick  = lastGrant;
        idx   = lastGrant;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = lastGrant + IDX_W'(k);
            if (!found && reqReadyInput[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clockInput or negedge resetInput) begin
        if (!resetInput) begin
            state             <= IDLE;
            lastGrant         <= IDX_W'(NUM_REQ - 1);
            grant             <= '0;
            reqAckOutput      <= '0;
            stdOutReadyOutput <= 1'b0;
            stdOutDataOutput  <= '0;
`ifdef STDOUT_ARB_SOURCE_TAG_EN
            stdOutSourceOutput <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    reqAckOutput      <= '0;
                    stdOutReadyOutput <= 1'b0;
                    if (found) begin
                        grant             <= pick;
                        stdOutDataOutput  <= reqDataInput[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                        stdOutReadyOutput <= 1'b1;
`ifdef STDOUT_ARB_SOURCE_TAG_EN
                        stdOutSourceOutput <= pick;
`endif
                        state             <= SEND;
                    end
                end
                SEND: begin
                    if (stdOutAckInput) begin
                        stdOutReadyOutput <= 1'b0;
                        reqAckOutput      <= NUM_REQ'(1) << grant;
                        state             <= ACKREQ;
                    end
                end
                ACKREQ: begin
                    reqAckOutput <= '0;
                    lastGrant    <= grant;
                    state        <= IDLE;
                end
                default: begin
                    reqAckOutput      <= '0;
                    stdOutReadyOutput <= 1'b0;
                    state             <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stdout_arbiter.sv
// Directed bench for stdout_arbiter: reset, single request, contention, wrap, stall, async reset.
module tb_stdout_arbiter;

    logic             clockInput = 1'b0;
    logic             resetInput;
    logic [3:0]       reqReadyInput;
    logic [3:0][31:0] dataVec;
    logic [3:0]       reqAckOutput;
    logic             stdOutReadyOutput;
    logic [31:0]      stdOutDataOutput;
    logic             stdOutAckInput;
`ifdef STDOUT_ARB_SOURCE_TAG_EN
    logic [1:0]       stdOutSourceOutput;
`endif

    int nCompared = 0;
    int nMismatch = 0;

    stdout_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4)) dut (
        .clockInput        (clockInput),
        .resetInput        (resetInput),
        .reqReadyInput     (reqReadyInput),
        .reqDataInput      (dataVec),
        .reqAckOutput      (reqAckOutput),
        .stdOutReadyOutput (stdOutReadyOutput),
        .stdOutDataOutput  (stdOutDataOutput),
`ifdef STDOUT_ARB_SOURCE_TAG_EN
        .stdOutSourceOutput(stdOutSourceOutput),
`endif
        .stdOutAckInput    (stdOutAckInput)
    );

    always #5 clockInput = ~clockInput;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
    task automatic step();
        @(posedge clockInput);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetInput     = 1'b0;
        reqReadyInput  = 4'b0000;
        stdOutAckInput = 1'b0;
        for (int i = 0; i < 4; i++) dataVec[i] = 32'hA000_0000 | i;

        // Reset state
        step(); step();
        chk("rst_ready", {31'd0, stdOutReadyOutput}, 32'd0);
        chk("rst_data", stdOutDataOutput, 32'd0);
        chk("rst_ack", {28'd0, reqAckOutput}, 32'd0);

        // Full contention with immediate ack: grants 0,1,2,3,0, one word per 3 cycles
        reqReadyInput  = 4'b1111;
        stdOutAckInput = 1'b1;
        resetInput     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("cont_ready", {31'd0, stdOutReadyOutput}, 32'd1);
            chk("cont_data", stdOutDataOutput, 32'hA000_0000 | (k % 4));
            step();
            chk("cont_ack", {28'd0, reqAckOutput}, 32'd1 << (k % 4));
            chk("cont_rdy_low", {31'd0, stdOutReadyOutput}, 32'd0);
            step();
            chk("cont_idle_ack", {28'd0, reqAckOutput}, 32'd0);
        end
        reqReadyInput  = 4'b0000;
        stdOutAckInput = 1'b0;

        // Single request from requester 2, consumer acks after 2 cycles
        reqReadyInput = 4'b0100;
        dataVec[2]    = 32'hDEAD_BEEF;
        step();
        chk("single_ready1", {31'd0, stdOutReadyOutput}, 32'd1);
        chk("single_data1", stdOutDataOutput, 32'hDEAD_BEEF);
        chk("single_noack1", {28'd0, reqAckOutput}, 32'd0);
        step();
        chk("single_ready2", {31'd0, stdOutReadyOutput}, 32'd1);
        chk("single_data2", stdOutDataOutput, 32'hDEAD_BEEF);
        stdOutAckInput = 1'b1;
        step();
        chk("single_ack", {28'd0, reqAckOutput}, 32'h4);
        chk("single_rdy_low", {31'd0, stdOutReadyOutput}, 32'd0);
        stdOutAckInput = 1'b0;
        reqReadyInput  = 4'b0000;
        step();
        chk("single_ack_once", {28'd0, reqAckOutput}, 32'd0);

        // Requester 3 alone, so the wrap test starts with lastGrant=3
        reqReadyInput  = 4'b1000;
        dataVec[3]     = 32'h3333_3333;
        stdOutAckInput = 1'b1;
        step();
        chk("r3_data", stdOutDataOutput, 32'h3333_3333);
`ifdef STDOUT_ARB_SOURCE_TAG_EN
        chk("r3_tag", {30'd0, stdOutSourceOutput}, 32'd3);
`endif
        step();
        chk("r3_ack", {28'd0, reqAckOutput}, 32'h8);
        reqReadyInput  = 4'b0000;
        stdOutAckInput = 1'b0;
        step();

        // Wrap-around: 3 and 1 together after 3 served -> 1 first, then 3
        reqReadyInput  = 4'b1010;
        dataVec[1]     = 32'h1111_AAAA;
        dataVec[3]     = 32'h3333_BBBB;
        stdOutAckInput = 1'b1;
        step();
        chk("wrap_data1", stdOutDataOutput, 32'h1111_AAAA);
        step();
        chk("wrap_ack1", {28'd0, reqAckOutput}, 32'h2);
        reqReadyInput = 4'b1000;
        step();
        step();
        chk("wrap_data3", stdOutDataOutput, 32'h3333_BBBB);
        step();
        chk("wrap_ack3", {28'd0, reqAckOutput}, 32'h8);
        reqReadyInput  = 4'b0000;
        stdOutAckInput = 1'b0;
        step();

        // Stall 10 cycles while requester 0 withdraws and changes its data
        reqReadyInput = 4'b0001;
        dataVec[0]    = 32'hCAFE_0000;
        step();
        chk("stall_data0", stdOutDataOutput, 32'hCAFE_0000);
        reqReadyInput = 4'b0000;
        dataVec[0]    = 32'h0BAD_F00D;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_ready", {31'd0, stdOutReadyOutput}, 32'd1);
            chk("stall_data", stdOutDataOutput, 32'hCAFE_0000);
            chk("stall_noack", {28'd0, reqAckOutput}, 32'd0);
        end
        stdOutAckInput = 1'b1;
        step();
        chk("stall_ack", {28'd0, reqAckOutput}, 32'h1);
        stdOutAckInput = 1'b0;
        step();

        // Async reset during SEND; lastGrant=0 so requester 2 wins before reset
        reqReadyInput = 4'b0101;
        dataVec[0]    = 32'h0000_0A0A;
        dataVec[2]    = 32'h0000_0C0C;
        step();
        chk("rs_pre_data", stdOutDataOutput, 32'h0000_0C0C);
        #2 resetInput = 1'b0;
        #1;
        chk("rs_async_ready", {31'd0, stdOutReadyOutput}, 32'd0);
        chk("rs_async_data", stdOutDataOutput, 32'd0);
        chk("rs_async_ack", {28'd0, reqAckOutput}, 32'd0);
        stdOutAckInput = 1'b1;
        step();
        chk("rs_hold_ack", {28'd0, reqAckOutput}, 32'd0);
        stdOutAckInput = 1'b0;
        resetInput     = 1'b1;
        step();
        chk("rs_post_ready", {31'd0, stdOutReadyOutput}, 32'd1);
        chk("rs_post_data", stdOutDataOutput, 32'h0000_0A0A);
        stdOutAckInput = 1'b1;
        step();
        chk("rs_post_ack", {28'd0, reqAckOutput}, 32'h1);
        reqReadyInput  = 4'b0000;
        stdOutAckInput = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
